jaddr_encoder: RTL

Jump-target encoder: the inverse of the shift-left-2 jump aggregator. Takes a 32-bit byte target address, the PC region it is relative to, and a J/JAL opcode, and produces the J-type instruction word {op, target[27:2]}. It also flags targets that the aggregator could not reconstruct. It sits in the assembler/loader path ahead of instruction memory writes. Input and output use valid/ready streams with a 2-entry skid buffer, and a saturating error counter supports bring-up.

---
 rtl/jaddr_pkg.sv | 29 ++
 rtl/jenc_skid.sv | 81 ++++++++
 rtl/jaddr_encoder.sv | 63 ++++++
 3 files changed

// File: rtl/jaddr_pkg.sv
// Shared types and constants for the J-type jump-target encoder and its skid buffer.
package jaddr_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_REGION   = 1;
    localparam int ERR_OPCODE   = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  err;
    } jenc_entry_t;

    localparam int ENTRY_W = $bits(jenc_entry_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // The inverse of the shift-left-2 jump aggregator: drop the region nibble and the byte offset.
    function automatic logic [31:0] jenc_word(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

endpackage

// File: rtl/jenc_skid.sv
// Two-entry valid/ready skid buffer of jenc_entry_t; in_ready is a pure function of state.
module jenc_skid
    import jaddr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ENTRY_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_data
);

    skid_state_t state_q, state_d;
    jenc_entry_t head_p0, tail_p1;
    jenc_entry_t in_entry;
    logic        head_ld, head_from_tail, tail_ld;
    logic        accept, deliver;

    assign in_entry = jenc_entry_t'(in_data);
    assign accept   = in_valid && (state_q != TWO);
    assign deliver  = out_ready && (state_q != EMPTY);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b1;
        out_valid      = 1'b0;
        head_ld        = 1'b0;
        head_from_tail = 1'b0;
        tail_ld        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_ld = 1'b1;
                end
            end
            ONE: begin
                out_valid = 1'b1;
                if (accept && !deliver) begin
                    state_d = TWO;
                    tail_ld = 1'b1;
                end else if (deliver && !accept) begin
                    state_d = EMPTY;
                end else if (accept && deliver) begin
                    head_ld = 1'b1;
                end
            end
            TWO: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                if (deliver) begin
                    state_d        = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Storage stage: head feeds the output, tail holds the skid word while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_p0 <= '0;
            tail_p1 <= '0;
        end else begin
            if (head_ld)             head_p0 <= in_entry;
            else if (head_from_tail) head_p0 <= tail_p1;
            if (tail_ld)             tail_p1 <= in_entry;
        end
    end

    assign out_data = head_p0;

endmodule

// File: rtl/jaddr_encoder.sv
// Jump-target encoder: packs {op, target[27:2]}, flags unreconstructable targets, counts errors.
module jaddr_encoder
    import jaddr_pkg::*;
#(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_target,
    input  logic [31:0]     in_pc,
    input  logic [5:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [2:0]      out_err,
    output logic [ERRW-1:0] err_count
);

    jenc_entry_t enc_entry;
    jenc_entry_t out_entry;
    logic [ENTRY_W-1:0] out_data;
    logic        accept;
    logic        unused_pc_low;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign unused_pc_low = ^in_pc[27:0];

    always_comb begin
        enc_entry                   = '0;
        enc_entry.instr             = jenc_word(in_op, in_target);
        enc_entry.err[ERR_MISALIGN] = |in_target[1:0];
        enc_entry.err[ERR_REGION]   = (in_target[31:28] != in_pc[31:28]);
        enc_entry.err[ERR_OPCODE]   = !((in_op == OP_J) || (in_op == OP_JAL));
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst)                        err_count <= '0;
        else if (accept && |enc_entry.err) err_count <= sat_inc(err_count);
    end

    jenc_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_entry = jenc_entry_t'(out_data);
    assign out_instr = out_entry.instr;
    assign out_err   = out_entry.err;

endmodule
